// File: rtl/apb_svt_slave_mem_if.sv
// apb_svt_slave_mem_if: APB completer bus bundle with master and slave modports
interface apb_svt_slave_mem_if #(
  parameter int PADDR_WIDTH = 32,
  parameter int PDATA_WIDTH = 32
);
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [PADDR_WIDTH-1:0]   paddr;
  logic [PDATA_WIDTH-1:0]   pwdata;
  logic [PDATA_WIDTH/8-1:0] pstrb;
  logic [2:0]               pprot;
  logic [PDATA_WIDTH-1:0]   prdata;
  logic                     pready;
  logic                     pslverr;
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_svt_slave_mem.sv
// apb_svt_slave_mem: APB completer with word memory, wait states, byte strobes, range/alignment errors; APB_SVT_SLAVE_PPROT_CHECK_EN adds non-secure upper-half protection errors
module apb_svt_slave_mem #(
  parameter int PADDR_WIDTH = 32,
  parameter int PDATA_WIDTH = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic                pclk,
  input logic                preset,
  apb_svt_slave_mem_if.slave bus
);
  localparam int NB = PDATA_WIDTH / 8;
  localparam int AL = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                 state;
  logic [3:0]             cnt;
  logic [IW-1:0]          idx_q;
  logic                   wr_q;
  logic                   err_q;
  logic [PDATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]          strb_q;
  logic [2:0]             prot_q;
  logic                   pready_q;
  logic                   pslverr_q;
  logic [PDATA_WIDTH-1:0] prdata_q;
  logic [PDATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IW-1:0]          idx_in;
  logic                   err_in;
  logic                   setup;
  logic                   access;
  logic                   unused_prot;
  assign idx_in = bus.paddr[IW+AL-1:AL];
  assign setup  = bus.psel && !bus.penable;
  assign access = bus.psel && bus.penable;
`ifdef APB_SVT_SLAVE_PPROT_CHECK_EN
  assign err_in = bus.paddr >= PADDR_WIDTH'(MEM_DEPTH * NB) ||
                  (bus.paddr & PADDR_WIDTH'(NB - 1)) != '0 ||
                  (bus.pprot[1] && idx_in[IW-1]);
`else
  assign err_in = bus.paddr >= PADDR_WIDTH'(MEM_DEPTH * NB) ||
                  (bus.paddr & PADDR_WIDTH'(NB - 1)) != '0;
`endif
  assign unused_prot  = ^prot_q;
  assign bus.pready   = pready_q;
  assign bus.pslverr  = pslverr_q;
  assign bus.prdata   = prdata_q;
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (setup) begin
          idx_q   <= idx_in;
          wr_q    <= bus.pwrite;
          err_q   <= err_in;
          wdata_q <= bus.pwdata;
          strb_q  <= bus.pstrb;
          prot_q  <= bus.pprot;
          if (WAIT_CYCLES == 0) begin
            state     <= RESP;
            pready_q  <= 1'b1;
            pslverr_q <= err_in;
            prdata_q  <= (err_in || bus.pwrite) ? '0 : mem[idx_in];
          end else begin
            state <= WAIT;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        WAIT: if (!access) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt == 4'd1) begin
          state     <= RESP;
          cnt       <= '0;
          pready_q  <= 1'b1;
          pslverr_q <= err_q;
          prdata_q  <= (err_q || wr_q) ? '0 : mem[idx_q];
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
      endcase
    end
  end
  always_ff @(posedge pclk) begin
    if (!preset && state == RESP && wr_q && !err_q && access)
      for (int b = 0; b < NB; b++)
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
  end
endmodule

// File: tb/tb_apb_svt_slave_mem.sv
// tb_apb_svt_slave_mem: randomized and directed checks of two completers (0 and 3 wait states) against a word-array model
module tb_apb_svt_slave_mem;
  localparam int WS[2] = '{0, 3};
  logic clk = 1'b0;
  logic preset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_pulse;
  logic        psel_v[2], penable_v[2], pwrite_v[2];
  logic [31:0] paddr_v[2], pwdata_v[2];
  logic [3:0]  pstrb_v[2];
  logic [2:0]  pprot_v[2];
  logic        pready_v[2], pslverr_v[2];
  logic [31:0] prdata_v[2];
  logic [31:0] ref_mem[2][256];
  bit          known[2][256];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  apb_svt_slave_mem_if #(.PADDR_WIDTH(32), .PDATA_WIDTH(32)) b0 ();
  apb_svt_slave_mem_if #(.PADDR_WIDTH(32), .PDATA_WIDTH(32)) b1 ();
  assign b0.psel = psel_v[0];       assign b1.psel = psel_v[1];
  assign b0.penable = penable_v[0]; assign b1.penable = penable_v[1];
  assign b0.pwrite = pwrite_v[0];   assign b1.pwrite = pwrite_v[1];
  assign b0.paddr = paddr_v[0];     assign b1.paddr = paddr_v[1];
  assign b0.pwdata = pwdata_v[0];   assign b1.pwdata = pwdata_v[1];
  assign b0.pstrb = pstrb_v[0];     assign b1.pstrb = pstrb_v[1];
  assign b0.pprot = pprot_v[0];     assign b1.pprot = pprot_v[1];
  assign pready_v[0] = b0.pready;   assign pready_v[1] = b1.pready;
  assign pslverr_v[0] = b0.pslverr; assign pslverr_v[1] = b1.pslverr;
  assign prdata_v[0] = b0.prdata;   assign prdata_v[1] = b1.prdata;
  apb_svt_slave_mem #(.WAIT_CYCLES(0)) u0 (.pclk(clk), .preset(preset), .bus(b0.slave));
  apb_svt_slave_mem #(.WAIT_CYCLES(3)) u1 (.pclk(clk), .preset(preset), .bus(b1.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] pr);
    bit e = a >= 32'd1024 || (a % 4) != 0;
`ifdef APB_SVT_SLAVE_PPROT_CHECK_EN
    e = e || (pr[1] && (a / 4) >= 128);
`else
    e = e || (pr[1] && 1'b0);
`endif
    return e;
  endfunction
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output bit er, output int lat);
    psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr;
    paddr_v[d] = a; pwdata_v[d] = wd; pstrb_v[d] = st; pprot_v[d] = pr;
    @(posedge clk); #1;
    penable_v[d] = 1'b1;
    lat = 1;
    while (!pready_v[d] && lat < 40) begin
      check("wait_prdata", prdata_v[d], 32'h0);
      check("wait_pslverr", 32'(pslverr_v[d]), 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    check("pready_seen", 32'(pready_v[d]), 32'h1);
    rd = prdata_v[d];
    er = pslverr_v[d];
    last_pulse = cyc;
    @(posedge clk); #1;
    check("pready_single", 32'(pready_v[d]), 32'h0);
    psel_v[d] = 1'b0; penable_v[d] = 1'b0;
  endtask
  task automatic op(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] st, input logic [2:0] pr, output logic [31:0] rd);
    bit er;
    int lat;
    bit e = exp_err(a, pr);
    int w = a / 4;
    xfer(d, wr, a, wd, st, pr, rd, er, lat);
    check("latency", 32'(lat), 32'(WS[d] + 1));
    check("pslverr", 32'(er), 32'(e));
    if (!wr && e) check("err_prdata", rd, 32'h0);
    if (!wr && !e && known[d][w]) check("rdata", rd, ref_mem[d][w]);
    if (wr && !e) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) ref_mem[d][w][8*b +: 8] = wd[8*b +: 8];
      known[d][w] = known[d][w] || st == 4'hF;
    end
  endtask
  initial begin
    logic [31:0] rd;
    int p0, p1;
    for (int d = 0; d < 2; d++) begin
      psel_v[d] = 0; penable_v[d] = 0; pwrite_v[d] = 0;
      paddr_v[d] = 0; pwdata_v[d] = 0; pstrb_v[d] = 0; pprot_v[d] = 0;
    end
    repeat (3) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        check("rst_pready", 32'(pready_v[d]), 32'h0);
        check("rst_pslverr", 32'(pslverr_v[d]), 32'h0);
        check("rst_prdata", prdata_v[d], 32'h0);
      end
    end
    preset = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check("post_rst_pready", 32'(pready_v[d]), 32'h0);
      check("post_rst_prdata", prdata_v[d], 32'h0);
    end
    op(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd);
    op(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, rd);
    check("w0_readback", rd, 32'hDEADBEEF);
    op(1, 1, 32'h20, 32'h11223344, 4'hF, 3'b000, rd);
    op(1, 1, 32'h20, 32'hAABBCCDD, 4'h5, 3'b000, rd);
    op(1, 0, 32'h20, 32'h0, 4'h0, 3'b000, rd);
    check("strobe_merge", rd, 32'h11BB33DD);
    for (int d = 0; d < 2; d++) begin
      op(d, 1, 32'h0, 32'h01020304, 4'hF, 3'b000, rd);
      op(d, 0, 32'h400, 32'h0, 4'h0, 3'b000, rd);
      op(d, 1, 32'h2, 32'hFFFFFFFF, 4'hF, 3'b000, rd);
      op(d, 0, 32'h0, 32'h0, 4'h0, 3'b000, rd);
      check("err_no_write", rd, 32'h01020304);
    end
    op(0, 1, 32'h40, 32'h5, 4'hF, 3'b000, rd);
    p0 = last_pulse;
    op(0, 0, 32'h40, 32'h0, 4'h0, 3'b000, rd);
    p1 = last_pulse;
    check("b2b_read", rd, 32'h5);
    check("b2b_gap1", 32'(p1 - p0), 32'd2);
    op(0, 1, 32'h40, 32'h6, 4'hF, 3'b000, rd);
    check("b2b_gap2", 32'(last_pulse - p1), 32'd2);
    op(0, 0, 32'h40, 32'h0, 4'h0, 3'b000, rd);
    check("b2b_final", rd, 32'h6);
    op(1, 1, 32'h30, 32'hCAFE0001, 4'hF, 3'b000, rd);
    psel_v[1] = 1; penable_v[1] = 0; pwrite_v[1] = 1;
    paddr_v[1] = 32'h30; pwdata_v[1] = 32'h0BAD0BAD; pstrb_v[1] = 4'hF; pprot_v[1] = 0;
    @(posedge clk); #1;
    penable_v[1] = 1;
    check("abort_wait1", 32'(pready_v[1]), 32'h0);
    @(posedge clk); #1;
    preset = 1'b1;
    check("abort_wait2", 32'(pready_v[1]), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_pulse", 32'(pready_v[1]), 32'h0);
      psel_v[1] = 0; penable_v[1] = 0;
    end
    preset = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", 32'(pready_v[1]), 32'h0);
    op(1, 0, 32'h30, 32'h0, 4'h0, 3'b000, rd);
    check("abort_mem_kept", rd, 32'hCAFE0001);
`ifdef APB_SVT_SLAVE_PPROT_CHECK_EN
    op(0, 1, 32'd800, 32'h12345678, 4'hF, 3'b000, rd);
    op(0, 1, 32'd800, 32'h9ABCDEF0, 4'hF, 3'b010, rd);
    op(0, 0, 32'd800, 32'h0, 4'h0, 3'b000, rd);
    check("prot_blocked", rd, 32'h12345678);
    op(0, 0, 32'd800, 32'h0, 4'h0, 3'b010, rd);
    check("prot_read_zero", rd, 32'h0);
`endif
    for (int i = 0; i < 200; i++) begin
      int d = $urandom % 2;
      int r = $urandom % 10;
      logic [31:0] a = 4 * ($urandom_range(0, 15) + 128 * ($urandom % 2));
      logic [3:0] st = ($urandom % 2) ? 4'hF : 4'($urandom);
      if (r == 0) a = 32'h400 + 4 * $urandom_range(0, 63);
      if (r == 1) a = a + $urandom_range(1, 3);
      op(d, bit'($urandom % 2), a, $urandom, st, 3'($urandom), rd);
      if ($urandom % 3 == 0) begin
        @(posedge clk); #1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
